ifft_1d_8_seq: RTL and testbench

IFFT_1D_8_SEQ -- requirements
Module: ifft_1d_8_seq

---
 rtl/ifft_1d_8_seq.sv | 132 +++++++++++++
 tb/tb_ifft_1d_8_seq.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_1d_8_seq.sv
// ifft_1d_8_seq: 8-point radix-2 DIT inverse FFT, one butterfly per cycle; IFFT_SCALE_EN enables 1/8 scaling
module ifft_1d_8_seq (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_r,
    input  logic signed [15:0] in_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_r,
    output logic signed [15:0] out_i,
    output logic               out_last
);
`ifdef IFFT_SCALE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic signed [18:0] mem_r [8];
    logic signed [18:0] mem_i [8];
    logic in_fire, out_fire, out_load;
    logic [1:0] st, bf, m;
    logic [2:0] ia, ib, ld_addr;
    logic signed [15:0] wr, wi;
    logic signed [35:0] pr, pi;
    logic signed [18:0] tr, ti, nar, nai, nbr, nbi;
    logic signed [19:0] sar, sai, sbr, sbi;

    function automatic logic signed [15:0] sat(input logic signed [18:0] v);
        return v > 19'sd32767 ? 16'sd32767 : v < -19'sd32768 ? -16'sd32768 : $signed(v[15:0]);
    endfunction

    assign in_ready = state == LOAD;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_load = state == DRAIN && !cnt[3] && (!out_valid || out_ready);
    assign ld_addr  = {cnt[0], cnt[1], cnt[2]};

    // butterfly addressing, twiddle selection and arithmetic for the current compute step
    always_comb begin
        st  = cnt[3:2];
        bf  = cnt[1:0];
        ia  = st == 2'd0 ? {bf, 1'b0} : st == 2'd1 ? {bf[1], 1'b0, bf[0]} : {1'b0, bf};
        ib  = ia + (st == 2'd0 ? 3'd1 : st == 2'd1 ? 3'd2 : 3'd4);
        m   = st == 2'd0 ? 2'd0 : st == 2'd1 ? {bf[0], 1'b0} : bf;
        wr  = m == 2'd0 ? 16'sd16384 : m == 2'd1 ? 16'sd11585 : m == 2'd2 ? 16'sd0 : -16'sd11585;
        wi  = m == 2'd0 ? 16'sd0 : m == 2'd2 ? 16'sd16384 : 16'sd11585;
        pr  = 36'(mem_r[ib]) * 36'(wr) - 36'(mem_i[ib]) * 36'(wi);
        pi  = 36'(mem_r[ib]) * 36'(wi) + 36'(mem_i[ib]) * 36'(wr);
        tr  = 19'((pr + 36'sd8192) >>> 14);
        ti  = 19'((pi + 36'sd8192) >>> 14);
        sar = 20'(mem_r[ia]) + 20'(tr);
        sai = 20'(mem_i[ia]) + 20'(ti);
        sbr = 20'(mem_r[ia]) - 20'(tr);
        sbi = 20'(mem_i[ia]) - 20'(ti);
        nar = 19'(sar >>> SH);
        nai = 19'(sai >>> SH);
        nbr = 19'(sbr >>> SH);
        nbi = 19'(sbi >>> SH);
    end

    // next state and shared sample/butterfly/drain counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOAD: if (in_fire) begin
                cnt_nx   = cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
                state_nx = cnt == 4'd7 ? COMPUTE : LOAD;
            end
            COMPUTE: begin
                cnt_nx   = cnt == 4'd11 ? 4'd0 : cnt + 4'd1;
                state_nx = cnt == 4'd11 ? DRAIN : COMPUTE;
            end
            DRAIN: begin
                cnt_nx   = out_fire && out_last ? 4'd0 : out_load ? cnt + 4'd1 : cnt;
                state_nx = out_fire && out_last ? LOAD : DRAIN;
            end
            default: begin
                state_nx = LOAD;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= LOAD;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // in-place register file: bit-reversed loads, butterfly write-back
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_r[ld_addr] <= 19'(in_r);
            mem_i[ld_addr] <= 19'(in_i);
        end
        if (state == COMPUTE) begin
            mem_r[ia] <= nar;
            mem_i[ia] <= nai;
            mem_r[ib] <= nbr;
            mem_i[ib] <= nbi;
        end
    end

    // registered output stage, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_r     <= 16'sd0;
            out_i     <= 16'sd0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_last  <= cnt[2:0] == 3'd7;
            out_r     <= sat(mem_r[cnt[2:0]]);
            out_i     <= sat(mem_i[cnt[2:0]]);
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifft_1d_8_seq.sv
// tb_ifft_1d_8_seq: randomized self-checking bench against an arithmetic IFFT reference
module tb_ifft_1d_8_seq;
    typedef int a8_t[8];
    typedef bit b8_t[8];
    logic clk = 0;
    logic reset_n = 0;
    logic in_valid = 0;
    logic in_ready;
    logic signed [15:0] in_r = 0;
    logic signed [15:0] in_i = 0;
    logic out_valid;
    logic out_ready = 0;
    logic signed [15:0] out_r;
    logic signed [15:0] out_i;
    logic out_last;
    int total = 0;
    int bad = 0;
    int edges = 0;

    ifft_1d_8_seq dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        edges++;
        #1;
    endtask

    function automatic int w19(input longint v);
        logic [18:0] t;
        t = v[18:0];
        return int'($signed(t));
    endfunction

    function automatic int brev(input int k);
        return int'({k[0], k[1], k[2]});
    endfunction

    function automatic int sat16(input longint v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
    endfunction

    // reference: textbook iterative DIT over doubling spans, fixed-point rules applied per butterfly
    task automatic model(input a8_t xr, input a8_t xi, output a8_t yr, output a8_t yi);
        longint ar[8];
        longint ai[8];
        int wr_t[4];
        int wi_t[4];
        wr_t = '{16384, 11585, 0, -11585};
        wi_t = '{0, 11585, 16384, 11585};
        for (int k = 0; k < 8; k++) begin
            ar[brev(k)] = xr[k];
            ai[brev(k)] = xi[k];
        end
        for (int h = 1; h < 8; h *= 2)
            for (int g = 0; g < 8; g += 2 * h)
                for (int j = 0; j < h; j++) begin
                    int p, q, mm;
                    longint tr, ti, a_r, a_i;
                    mm = j * (4 / h);
                    p = g + j;
                    q = p + h;
                    tr = w19((ar[q] * wr_t[mm] - ai[q] * wi_t[mm] + 8192) >>> 14);
                    ti = w19((ar[q] * wi_t[mm] + ai[q] * wr_t[mm] + 8192) >>> 14);
                    a_r = ar[p];
                    a_i = ai[p];
`ifdef IFFT_SCALE_EN
                    ar[p] = w19((a_r + tr) >>> 1);
                    ai[p] = w19((a_i + ti) >>> 1);
                    ar[q] = w19((a_r - tr) >>> 1);
                    ai[q] = w19((a_i - ti) >>> 1);
`else
                    ar[p] = w19(a_r + tr);
                    ai[p] = w19(a_i + ti);
                    ar[q] = w19(a_r - tr);
                    ai[q] = w19(a_i - ti);
`endif
                end
        for (int n = 0; n < 8; n++) begin
            yr[n] = sat16(ar[n]);
            yi[n] = sat16(ai[n]);
        end
    endtask

    task automatic gen(output a8_t r, output a8_t i, input int lim);
        for (int k = 0; k < 8; k++) begin
            r[k] = int'($urandom_range(0, 2 * lim)) - lim;
            i[k] = int'($urandom_range(0, 2 * lim)) - lim;
        end
    endtask

    task automatic send(input a8_t xr, input a8_t xi, input bit gaps, output int acc, output bit to);
        int k = 0;
        int cyc = 0;
        bit go;
        acc = -1;
        while (k < 8 && cyc < 400) begin
            in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
            in_r = 16'(xr[k]);
            in_i = 16'(xi[k]);
            go = in_valid && in_ready;
            tick;
            cyc++;
            if (go) begin
                k++;
                acc = edges;
            end
        end
        in_valid = 0;
        to = k < 8;
    endtask

    // mode 0: always ready, 1: random stalls, 2: five-cycle stall after the third transfer
    task automatic collect(input int mode, output a8_t yr, output a8_t yi, output b8_t lst,
                           output int first, output int hold_err, output bit rdy_after, output bit to);
        int n = 0;
        int cyc = 0;
        int stall = 0;
        bit prev = 0;
        logic signed [15:0] hr = 0;
        logic signed [15:0] hi = 0;
        logic hl = 0;
        first = -1;
        hold_err = 0;
        while (n < 8 && cyc < 400) begin
            out_ready = mode == 1 ? ($urandom % 2 == 0) : mode == 2 ? !(n == 3 && stall < 5) : 1'b1;
            if (mode == 2 && n == 3 && stall < 5) stall++;
            if (out_valid && first < 0) first = edges;
            if (prev && (out_r !== hr || out_i !== hi || out_last !== hl || out_valid !== 1'b1)) hold_err++;
            prev = out_valid && !out_ready;
            hr = out_r;
            hi = out_i;
            hl = out_last;
            if (out_valid && out_ready) begin
                yr[n] = out_r;
                yi[n] = out_i;
                lst[n] = out_last;
                n++;
            end
            tick;
            cyc++;
        end
        out_ready = 1;
        rdy_after = in_ready === 1'b1 && out_valid === 1'b0;
        to = n < 8;
    endtask

    task automatic do_reset;
        reset_n = 0;
        tick;
        reset_n = 1;
    endtask

    task automatic test_reset;
        reset_n = 0;
        out_ready = 1;
        tick;
        tick;
        total += 5;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last got=%b want=0", out_last); end
        if (out_r !== 16'sd0) begin bad++; $display("FAIL reset out_r got=%0d want=0", out_r); end
        if (out_i !== 16'sd0) begin bad++; $display("FAIL reset out_i got=%0d want=0", out_i); end
        reset_n = 1;
        tick;
    endtask

    task automatic test_impulse;
        a8_t xr, xi, yr, yi;
        b8_t lst;
        int acc, first, herr, want;
        bit rdy, to1, to2;
        xr = '{256, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef IFFT_SCALE_EN
        want = 32;
`else
        want = 256;
`endif
        send(xr, xi, 0, acc, to1);
        collect(0, yr, yi, lst, first, herr, rdy, to2);
        total++;
        if (to1 || to2) begin bad++; $display("FAIL impulse_timeout in=%b out=%b want=0", to1, to2); end
        for (int n = 0; n < 8; n++) begin
            total += 3;
            if (yr[n] !== want) begin bad++; $display("FAIL impulse_re[%0d] got=%0d want=%0d", n, yr[n], want); end
            if (yi[n] !== 0) begin bad++; $display("FAIL impulse_im[%0d] got=%0d want=0", n, yi[n]); end
            if (lst[n] !== (n == 7)) begin bad++; $display("FAIL impulse_last[%0d] got=%b want=%b", n, lst[n], n == 7); end
        end
        total += 2;
        if (first - acc !== 13) begin bad++; $display("FAIL impulse_latency got=%0d want=13", first - acc); end
        if (!rdy) begin bad++; $display("FAIL impulse_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_tone;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr;
        bit rdy, to1, to2;
        real dv, re, im, dr, di;
`ifdef IFFT_SCALE_EN
        dv = 8.0;
`else
        dv = 1.0;
`endif
        xr = '{0, 2048, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        model(xr, xi, er, ei);
        send(xr, xi, 1, acc, to1);
        collect(0, yr, yi, lst, first, herr, rdy, to2);
        total++;
        if (to1 || to2) begin bad++; $display("FAIL tone_timeout in=%b out=%b want=0", to1, to2); end
        for (int n = 0; n < 8; n++) begin
            re = 2048.0 * $cos(2.0 * 3.14159265358979 * n / 8.0) / dv;
            im = 2048.0 * $sin(2.0 * 3.14159265358979 * n / 8.0) / dv;
            dr = $itor(yr[n]) - re;
            di = $itor(yi[n]) - im;
            total += 4;
            if (dr > 1.01 || dr < -1.01) begin bad++; $display("FAIL tone_ideal_re[%0d] got=%0d want=%f", n, yr[n], re); end
            if (di > 1.01 || di < -1.01) begin bad++; $display("FAIL tone_ideal_im[%0d] got=%0d want=%f", n, yi[n], im); end
            if (yr[n] !== er[n]) begin bad++; $display("FAIL tone_re[%0d] got=%0d want=%0d", n, yr[n], er[n]); end
            if (yi[n] !== ei[n]) begin bad++; $display("FAIL tone_im[%0d] got=%0d want=%0d", n, yi[n], ei[n]); end
        end
    endtask

    task automatic test_saturation;
        a8_t xr, xi, yr, yi;
        b8_t lst;
        int acc, first, herr, v, w;
        bit rdy, to1, to2;
        for (int s = 0; s < 2; s++) begin
            v = s == 0 ? 32767 : -32768;
            for (int k = 0; k < 8; k++) begin
                xr[k] = v;
                xi[k] = 0;
            end
            send(xr, xi, 0, acc, to1);
            collect(1, yr, yi, lst, first, herr, rdy, to2);
            total++;
            if (to1 || to2) begin bad++; $display("FAIL sat_timeout in=%b out=%b want=0", to1, to2); end
            for (int n = 0; n < 8; n++) begin
                w = n == 0 ? v : 0;
                total += 2;
                if (yr[n] > w + 1 || yr[n] < w - 1) begin bad++; $display("FAIL sat_re[%0d] got=%0d want=%0d", n, yr[n], w); end
                if (yi[n] > 1 || yi[n] < -1) begin bad++; $display("FAIL sat_im[%0d] got=%0d want=0", n, yi[n]); end
            end
        end
    endtask

    task automatic test_stall;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr;
        bit rdy, to1, to2;
        gen(xr, xi, 4000);
        model(xr, xi, er, ei);
        send(xr, xi, 0, acc, to1);
        collect(2, yr, yi, lst, first, herr, rdy, to2);
        total += 4;
        if (to1 || to2) begin bad++; $display("FAIL stall_timeout in=%b out=%b want=0", to1, to2); end
        if (herr !== 0) begin bad++; $display("FAIL stall_hold got=%0d changes want=0", herr); end
        if (first - acc !== 13) begin bad++; $display("FAIL stall_latency got=%0d want=13", first - acc); end
        if (!rdy) begin bad++; $display("FAIL stall_ready_after got=%b want=1", in_ready); end
        for (int n = 0; n < 8; n++) begin
            total += 3;
            if (yr[n] !== er[n]) begin bad++; $display("FAIL stall_re[%0d] got=%0d want=%0d", n, yr[n], er[n]); end
            if (yi[n] !== ei[n]) begin bad++; $display("FAIL stall_im[%0d] got=%0d want=%0d", n, yi[n], ei[n]); end
            if (lst[n] !== (n == 7)) begin bad++; $display("FAIL stall_last[%0d] got=%b want=%b", n, lst[n], n == 7); end
        end
    endtask

    task automatic test_random;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr;
        bit rdy, to1, to2;
        for (int f = 0; f < 6; f++) begin
            gen(xr, xi, f % 2 ? 32767 : 2000);
            model(xr, xi, er, ei);
            send(xr, xi, 1, acc, to1);
            collect(1, yr, yi, lst, first, herr, rdy, to2);
            total += 3;
            if (to1 || to2) begin bad++; $display("FAIL rand_timeout frame=%0d in=%b out=%b want=0", f, to1, to2); end
            if (herr !== 0) begin bad++; $display("FAIL rand_hold frame=%0d got=%0d want=0", f, herr); end
            if (first - acc !== 13) begin bad++; $display("FAIL rand_latency frame=%0d got=%0d want=13", f, first - acc); end
            for (int n = 0; n < 8; n++) begin
                total += 3;
                if (yr[n] !== er[n]) begin bad++; $display("FAIL rand_re f%0d[%0d] got=%0d want=%0d", f, n, yr[n], er[n]); end
                if (yi[n] !== ei[n]) begin bad++; $display("FAIL rand_im f%0d[%0d] got=%0d want=%0d", f, n, yi[n], ei[n]); end
                if (lst[n] !== (n == 7)) begin bad++; $display("FAIL rand_last f%0d[%0d] got=%b want=%b", f, n, lst[n], n == 7); end
            end
        end
    endtask

    task automatic test_reset_compute;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr, seen;
        bit rdy, to1, to2;
        gen(xr, xi, 3000);
        send(xr, xi, 0, acc, to1);
        repeat (5) tick;
        do_reset;
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstcomp_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rstcomp_out_valid got=%b want=0", out_valid); end
        seen = 0;
        repeat (20) begin
            if (out_valid !== 1'b0) seen++;
            tick;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rstcomp_valid_after got=%0d cycles want=0", seen); end
        gen(xr, xi, 3000);
        model(xr, xi, er, ei);
        send(xr, xi, 1, acc, to1);
        collect(1, yr, yi, lst, first, herr, rdy, to2);
        total++;
        if (to1 || to2) begin bad++; $display("FAIL rstcomp_timeout in=%b out=%b want=0", to1, to2); end
        for (int n = 0; n < 8; n++) begin
            total += 2;
            if (yr[n] !== er[n]) begin bad++; $display("FAIL rstcomp_re[%0d] got=%0d want=%0d", n, yr[n], er[n]); end
            if (yi[n] !== ei[n]) begin bad++; $display("FAIL rstcomp_im[%0d] got=%0d want=%0d", n, yi[n], ei[n]); end
        end
    endtask

    task automatic test_reset_mid;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr, cyc;
        bit rdy, to1, to2;
        for (int s = 0; s < 2; s++) begin
            gen(xr, xi, 3000);
            if (s == 0) begin
                in_valid = 1;
                repeat (3) begin
                    in_r = 16'($urandom);
                    in_i = 16'($urandom);
                    tick;
                end
                in_valid = 0;
            end else begin
                send(xr, xi, 0, acc, to1);
                out_ready = 1;
                cyc = 0;
                while (out_valid !== 1'b1 && cyc < 50) begin
                    tick;
                    cyc++;
                end
                total++;
                if (cyc >= 50) begin bad++; $display("FAIL rstmid_wait got=timeout want=out_valid"); end
                repeat (3) tick;
            end
            do_reset;
            total += 2;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready s%0d got=%b want=1", s, in_ready); end
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid s%0d got=%b want=0", s, out_valid); end
            model(xr, xi, er, ei);
            send(xr, xi, 1, acc, to1);
            collect(1, yr, yi, lst, first, herr, rdy, to2);
            total++;
            if (to1 || to2) begin bad++; $display("FAIL rstmid_timeout s%0d in=%b out=%b want=0", s, to1, to2); end
            for (int n = 0; n < 8; n++) begin
                total += 2;
                if (yr[n] !== er[n]) begin bad++; $display("FAIL rstmid_re s%0d[%0d] got=%0d want=%0d", s, n, yr[n], er[n]); end
                if (yi[n] !== ei[n]) begin bad++; $display("FAIL rstmid_im s%0d[%0d] got=%0d want=%0d", s, n, yi[n], ei[n]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        a8_t xr, xi, yr, yi, er, ei;
        b8_t lst;
        int acc, first, herr;
        bit rdy, to1, to2;
        for (int f = 0; f < 2; f++) begin
            gen(xr, xi, 8000);
            model(xr, xi, er, ei);
            send(xr, xi, 0, acc, to1);
            collect(0, yr, yi, lst, first, herr, rdy, to2);
            total += 3;
            if (to1 || to2) begin bad++; $display("FAIL b2b_timeout f%0d in=%b out=%b want=0", f, to1, to2); end
            if (!rdy) begin bad++; $display("FAIL b2b_ready_after f%0d got=%b want=1", f, in_ready); end
            if (first - acc !== 13) begin bad++; $display("FAIL b2b_latency f%0d got=%0d want=13", f, first - acc); end
            for (int n = 0; n < 8; n++) begin
                total += 2;
                if (yr[n] !== er[n]) begin bad++; $display("FAIL b2b_re f%0d[%0d] got=%0d want=%0d", f, n, yr[n], er[n]); end
                if (yi[n] !== ei[n]) begin bad++; $display("FAIL b2b_im f%0d[%0d] got=%0d want=%0d", f, n, yi[n], ei[n]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_impulse;
        test_tone;
        test_saturation;
        test_stall;
        test_random;
        test_reset_compute;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
